// File: rtl/mul_booth_pipe.sv
// rtl/mul_booth_pipe.sv - pipelined radix-4 Booth / carry-save tree multiplier
//
// Purpose: full 2*WIDTH-bit product of two WIDTH-bit operands, each operand
// independently signed or unsigned. A valid/ready handshake runs on both
// sides, and a sideband tag travels with each operation.
//   S1: Booth row generation (registered)
//   S2: carry-save full-adder tree, N+1 rows down to 2 (registered only when
//       MUL_MID_REG_EN is defined)
//   S3: carry-propagate add into the output register
// Build option MUL_MID_REG_EN: defined -> latency/capacity 3, undefined -> 2.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (zeroes all state)
//   flush              drops every in-flight operation at the edge
//   in_valid/in_ready  operation handshake; in_a, in_b, in_*_signed, in_tag
//   out_valid/out_ready result handshake; out_prod, out_tag
module mul_booth_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_a_signed,
  input  logic               in_b_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int P  = 2 * WIDTH;
  localparam int N  = (WIDTH + 2) / 2;
  localparam int R0 = N + 1;  // Booth rows plus the constant correction row

  typedef logic [P-1:0] row_t;

  // Rows remaining after l levels of 3:2 compression.
  function automatic int rows_at(input int l);
    int r = R0;
    for (int k = 0; k < l; k++) if (r > 2) r = 2 * (r / 3) + r % 3;
    return r;
  endfunction

  function automatic int num_lvls();
    int r = R0;
    int c = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + r % 3;
      c++;
    end
    return c;
  endfunction

  // Start index of level l inside the flattened tree array.
  function automatic int lvl_off(input int l);
    int o = 0;
    for (int k = 0; k < l; k++) o += rows_at(k);
    return o;
  endfunction

  // Each row carries an inverted sign bit instead of a sign extension; this
  // adds +2^(WIDTH+2) per row, which the constant row takes back out.
  function automatic row_t k_row();
    row_t k = '0;
    for (int i = 0; i < N; i++) k = k - (row_t'(1) << (WIDTH + 2 + 2 * i));
    return k;
  endfunction

  function automatic row_t booth_row(input logic [WIDTH+1:0] a_x,
                                     input logic [2:0] sel, input int sh);
    logic [WIDTH+2:0] a1, a2, pp;
    a1 = {a_x[WIDTH+1], a_x};
    a2 = {a_x, 1'b0};
    case (sel)
      3'b001, 3'b010: pp = a1;
      3'b011:         pp = a2;
      3'b100:         pp = -a2;
      3'b101, 3'b110: pp = -a1;
      default:        pp = '0;
    endcase
    return row_t'({~pp[WIDTH+2], pp[WIDTH+1:0]}) << sh;
  endfunction

  localparam int   LV    = num_lvls();
  localparam int   TOT   = lvl_off(LV + 1);
  localparam int   OF    = lvl_off(LV);
  localparam row_t K_ROW = k_row();

  // ---------------- handshake ----------------
  logic s1_valid, s1_adv, s3_adv, in_fire;
  assign s3_adv = ~out_valid | out_ready;
`ifdef MUL_MID_REG_EN
  logic s2_valid, s2_adv;
  assign s2_adv = ~s2_valid | s3_adv;
  assign s1_adv = ~s1_valid | s2_adv;
`else
  assign s1_adv = ~s1_valid | s3_adv;
`endif
  assign in_ready = rst_n & ~flush & s1_adv;
  assign in_fire  = in_valid & in_ready;

  // ---------------- S1: Booth rows ----------------
  logic [WIDTH+1:0] a_ext, b_ext;
  logic [WIDTH+2:0] b_z;  // multiplier with the implicit b[-1]=0 below bit 0
  row_t             booth_rows [N];
  row_t             s1_rows    [N];
  logic [TAG_W-1:0] s1_tag;

  assign a_ext = {{2{in_a_signed & in_a[WIDTH-1]}}, in_a};
  assign b_ext = {{2{in_b_signed & in_b[WIDTH-1]}}, in_b};
  assign b_z   = {b_ext, 1'b0};

  for (genvar i = 0; i < N; i++) begin : g_booth
    assign booth_rows[i] = booth_row(a_ext, b_z[2*i+2:2*i], 2 * i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      for (int i = 0; i < N; i++) s1_rows[i] <= '0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= in_valid;
      if (in_fire) begin
        s1_tag <= in_tag;
        for (int i = 0; i < N; i++) s1_rows[i] <= booth_rows[i];
      end
    end
  end

  // ---------------- S2: carry-save tree ----------------
  row_t tree [TOT];

  for (genvar i = 0; i < N; i++) begin : g_lvl0
    assign tree[i] = s1_rows[i];
  end
  assign tree[N] = K_ROW;

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int RI = rows_at(l);
    localparam int GI = RI / 3;
    localparam int OI = lvl_off(l);
    localparam int OO = lvl_off(l + 1);
    for (genvar g = 0; g < GI; g++) begin : g_csa
      row_t x, y, z;
      assign x = tree[OI+3*g];
      assign y = tree[OI+3*g+1];
      assign z = tree[OI+3*g+2];
      assign tree[OO+2*g]   = x ^ y ^ z;
      assign tree[OO+2*g+1] = {(x[P-2:0] & y[P-2:0]) | (x[P-2:0] & z[P-2:0]) |
                               (y[P-2:0] & z[P-2:0]), 1'b0};
    end
    for (genvar r = 0; r < RI % 3; r++) begin : g_pass
      assign tree[OO+2*GI+r] = tree[OI+3*GI+r];
    end
  end

  logic [P-1:0]     fin_sum, fin_carry;
  logic             fin_valid;
  logic [TAG_W-1:0] fin_tag;

`ifdef MUL_MID_REG_EN
  logic [P-1:0]     s2_sum, s2_carry;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_carry <= '0;
      s2_tag   <= '0;
    end else begin
      if (flush)       s2_valid <= 1'b0;
      else if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid && !flush) begin
        s2_sum   <= tree[OF];
        s2_carry <= tree[OF+1];
        s2_tag   <= s1_tag;
      end
    end
  end

  assign fin_sum   = s2_sum;
  assign fin_carry = s2_carry;
  assign fin_valid = s2_valid;
  assign fin_tag   = s2_tag;
`else
  assign fin_sum   = tree[OF];
  assign fin_carry = tree[OF+1];
  assign fin_valid = s1_valid;
  assign fin_tag   = s1_tag;
`endif

  // ---------------- S3: final add ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_tag   <= '0;
    end else begin
      if (flush)       out_valid <= 1'b0;
      else if (s3_adv) out_valid <= fin_valid;
      if (s3_adv && fin_valid && !flush) begin
        out_prod <= fin_sum + fin_carry;
        out_tag  <= fin_tag;
      end
    end
  end
endmodule

// File: tb/tb_mul_booth_pipe.sv
// tb/tb_mul_booth_pipe.sv - self-checking bench for mul_booth_pipe
module tb_mul_booth_pipe;
  localparam int W  = 32;
  localparam int TW = 5;
`ifdef MUL_MID_REG_EN
  localparam int L = 3;
`else
  localparam int L = 2;
`endif

  typedef logic [2*W+TW-1:0] exp_t;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, in_a_signed, in_b_signed;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag, out_tag;
  logic          out_valid, out_ready;
  logic [2*W-1:0] out_prod;

  mul_booth_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_a_signed(in_a_signed), .in_b_signed(in_b_signed),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int first_xfer_cyc = 0;
  int last_xfer_cyc = 0;
  logic [TW-1:0] tag_ctr = '0;
  exp_t exp_q[$];

  logic seen_out, seen_in_ready, accepted, xfer;
  logic [2*W-1:0] seen_prod;
  logic [TW-1:0]  seen_tag;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sa, input logic sb);
    logic signed [2*W+1:0] ea, eb, pr;
    ea = sa ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
    eb = sb ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
    pr = ea * eb;
    return pr[2*W-1:0];
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    assert (got === want)
    else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // One clock: sample at the falling edge, score transfers, return 1 after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    seen_in_ready = in_ready;
    seen_out      = out_valid;
    seen_prod     = out_prod;
    seen_tag      = out_tag;
    accepted      = in_valid && in_ready;
    xfer          = out_valid && out_ready;
    if (xfer) begin
      if (xfer_cnt == 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      xfer_cnt++;
      chk("out_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_prod_tag", 128'({out_prod, out_tag}), 128'(e));
      end
    end
    if (accepted)
      exp_q.push_back({ref_mul(in_a, in_b, in_a_signed, in_b_signed), in_tag});
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    in_a = r[W-1:0];
    r = {$urandom(), $urandom()};
    in_b = r[W-1:0];
    in_a_signed = 1'($urandom_range(0, 1));
    in_b_signed = 1'($urandom_range(0, 1));
    in_tag = tag_ctr;
    tag_ctr++;
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sa, input logic sb, input logic [2*W-1:0] want);
    int n;
    in_a = a; in_b = b; in_a_signed = sa; in_b_signed = sb;
    in_tag = tag_ctr; tag_ctr++;
    in_valid = 1'b1;
    tick();
    chk({name, "_accept"}, 128'(accepted), 128'(1));
    in_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!seen_out && n < 10);
    chk({name, "_latency"}, 128'(n), 128'(L));
    chk({name, "_prod"}, 128'(seen_prod), 128'(want));
    chk({name, "_tag"}, 128'(seen_tag), 128'(in_tag));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] corner [4];
    logic [W-1:0] bp_a [5], bp_b [5];
    logic [2*W-1:0] hold_prod;
    int idx, n, rel_x, start_x;
    logic have;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_a_signed = 1'b0; in_b_signed = 1'b0; in_tag = '0;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", 128'(seen_out), 128'(0));
    chk("rst_out_prod", 128'(seen_prod), 128'(0));
    chk("rst_out_tag", 128'(seen_tag), 128'(0));
    chk("rst_in_ready", 128'(seen_in_ready), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 128'(seen_in_ready), 128'(1));

    // Directed cases
    directed("ss_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001);
    directed("uu_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
    directed("su_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001);
    directed("ss_min",  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);

    // Streaming: 100 back-to-back random ops
    xfer_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      rand_op();
      in_valid = 1'b1;
      tick();
      chk("stream_accept", 128'(accepted), 128'(1));
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("stream_count", 128'(xfer_cnt), 128'(100));
    chk("stream_no_gaps", 128'(last_xfer_cyc - first_xfer_cyc), 128'(99));

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [63:0] r;
      r = {$urandom(), $urandom()}; bp_a[i] = r[W-1:0];
      r = {$urandom(), $urandom()}; bp_b[i] = r[W-1:0];
    end
    idx = 0;
    have = 1'b0;
    hold_prod = '0;
    in_a = bp_a[0]; in_b = bp_b[0]; in_a_signed = 1'b1; in_b_signed = 1'b0;
    in_tag = tag_ctr;
    for (int t = 0; t < 8; t++) begin
      in_valid = 1'b1;
      tick();
      if (accepted) begin
        idx++;
        tag_ctr++;
        in_tag = tag_ctr;
        in_a = bp_a[idx % 5]; in_b = bp_b[idx % 5];
      end
      if (seen_out) begin
        if (!have) begin
          hold_prod = seen_prod;
          have = 1'b1;
        end else begin
          chk("bp_stable_prod", 128'(seen_prod), 128'(hold_prod));
        end
      end
    end
    chk("bp_accepted", 128'(idx), 128'(L));
    chk("bp_in_ready_low", 128'(seen_in_ready), 128'(0));
    chk("bp_out_valid", 128'(seen_out), 128'(1));
    out_ready = 1'b1;
    start_x = xfer_cnt;
    n = 0;
    while ((idx < 5 || exp_q.size() != 0) && n < 20) begin
      in_valid = (idx < 5);
      tick();
      n++;
      if (accepted) begin
        idx++;
        tag_ctr++;
        in_tag = tag_ctr;
        in_a = bp_a[idx % 5]; in_b = bp_b[idx % 5];
      end
    end
    in_valid = 1'b0;
    rel_x = xfer_cnt - start_x;
    chk("bp_drain_cycles", 128'(n), 128'(5));
    chk("bp_drain_count", 128'(rel_x), 128'(5));

    // Flush
    for (int i = 0; i < 3; i++) begin
      rand_op();
      in_valid = 1'b1;
      tick();
    end
    rand_op();
    flush = 1'b1;
    tick();
    chk("flush_in_ready", 128'(seen_in_ready), 128'(0));
    chk("flush_not_accepted", 128'(accepted), 128'(0));
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < L; i++) begin
      tick();
      chk("flush_out_valid_low", 128'(seen_out), 128'(0));
    end
    for (int i = 0; i < 3; i++) tick();
    directed("post_flush", 32'h0001_2345, 32'hFFFF_FFFE, 1'b0, 1'b1,
             ref_mul(32'h0001_2345, 32'hFFFF_FFFE, 1'b0, 1'b1));

    // Reset mid-stream with the pipe full
    out_ready = 1'b0;
    for (int i = 0; i < L; i++) begin
      rand_op();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_in_ready", 128'(seen_in_ready), 128'(0));
    rst_n = 1'b1;
    exp_q.delete();
    tick();
    chk("mid_rst_out_valid", 128'(seen_out), 128'(0));
    chk("mid_rst_out_prod", 128'(seen_prod), 128'(0));
    chk("mid_rst_in_ready_after", 128'(seen_in_ready), 128'(1));
    out_ready = 1'b1;

    // Corner operands under every sign combination
    corner[0] = '0;
    corner[1] = W'(1);
    corner[2] = '1;
    corner[3] = {1'b1, {(W-1){1'b0}}};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int s = 0; s < 4; s++) begin
          in_a = corner[i]; in_b = corner[j];
          in_a_signed = s[0]; in_b_signed = s[1];
          in_tag = tag_ctr; tag_ctr++;
          in_valid = 1'b1;
          tick();
          chk("corner_accept", 128'(accepted), 128'(1));
        end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("final_drain", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_booth_pipe.md
# mul_booth_pipe

Parametrised, pipelined radix-4 Booth / Wallace-tree multiplier for the execute stage. It takes two WIDTH-bit operands, with a signedness flag for each operand, and produces the full 2*WIDTH-bit product. Valid/ready handshakes on both sides let it stall with the backend. It is the generalised successor of the fixed 17-row compressor slice: row count, compressor depth and pipeline depth all follow from WIDTH. It also adds flush support and a passthrough tag.

## Interface
- WIDTH, 32, operand width; even, 8..64.
- TAG_W, 5, width of the sideband tag carried alongside each operation (e.g. destination register id).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  kills every in-flight operation; synchronous.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_a_signed  in  1  1 = in_a is two's complement; 0 = in_a is unsigned.
- in_b_signed  in  1  1 = in_b is two's complement; 0 = in_b is unsigned.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_prod  out  2*WIDTH  full product.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Operands are extended to WIDTH+2 bits. Each operand gets 2 extra bits: sign-extended when its flag is 1, zero-extended when 0.
- Radix-4 Booth recoding of the extended multiplier gives N = (WIDTH+2)/2 partial-product rows (17 for WIDTH=32). Each row uses sign-extension-prevention encoding.
- Stage S1 (Booth): row generation, registered.
- Stage S2 (compress): carry-save full-adder tree reduces the N rows to 2 rows of 2*WIDTH bits. The tree is built generatively from WIDTH.
- Stage S3 (final add): 2*WIDTH carry-propagate adder. Bits above 2*WIDTH are discarded, so the result is exact modulo 2^(2*WIDTH).
- Each stage has its own valid bit. The tag travels with its stage's data.
- Handshake and stalls:
  - A stage advances when it is empty or the next stage advances. The last stage advances when out_ready=1.
  - in_ready = rst_n & ~flush & (S1 empty | S1 advances). This is combinational from out_ready through the chain.
  - A transfer occurs when in_valid & in_ready; out transfer occurs when out_valid & out_ready.
  - With out_valid=1 and out_ready=0, out_prod and out_tag must stay stable.
- flush=1:
  - All stage valids clear at the edge and out_valid=0 next cycle.
  - The input offered in the same cycle is not accepted (in_ready=0).
  - The output in the flush cycle is still visible. Whether it is consumed that cycle is the consumer's decision, and it is never re-presented.
- Reset: same effect as flush. All stage data is also zeroed.
- Results leave strictly in acceptance order; there is no reordering and no bypass.

## Timing
- Reset values: out_valid=0, out_prod=0, out_tag=0. in_ready=0 while rst_n=0, then 1 in the first cycle after reset.
- Latency L = 3 cycles from input transfer to out_valid, with the S2 register present.
- Throughput: 1 operation per cycle when out_ready=1.
- Capacity: L operations. With out_ready held 0, in_ready falls after L accepted operations.
- Stall release: out_ready rising lets one operation drain and one enter in the same cycle.
- Flush and reset have priority over every other event in the same cycle.

## Configuration
- MUL_MID_REG_EN:
  - Defined: S2 output is registered and L=3.
  - Undefined: S2 and S3 merge into a single combinational stage and L=2, at a cost to the critical path. Capacity is then 2.
  - The handshake rules are identical in both builds.

## Test plan
- WIDTH=32 directed cases, each with a distinct tag:
  - 0xFFFFFFFF × 0xFFFFFFFF, both signed -> 0x0000000000000001.
  - Same operands, both unsigned -> 0xFFFFFFFE00000001.
  - a signed, b unsigned -> 0xFFFFFFFF00000001.
  - 0x80000000 × 0x80000000, both signed -> 0x4000000000000000.
  - Check each tag and that out_valid rises exactly L cycles after acceptance.
- Streaming: 100 back-to-back random ops with out_ready=1 -> 100 results on consecutive cycles, in order, matching the reference model.
- Backpressure: out_ready=0 while issuing 5 ops -> exactly L accepted and in_ready=0 afterwards. out_prod stays stable. Raising out_ready drains all 5 in order with no gaps.
- Flush: issue 3 ops, then assert flush on the next cycle together with in_valid=1 -> in_ready=0 that cycle, out_valid=0 for the following L cycles, no killed tag ever appears, and a new op afterwards completes normally.
- Reset mid-stream: rst_n low for 1 cycle with the pipe full -> out_valid=0 and out_prod=0 next cycle, in_ready=1 the cycle after.
- Repeat the random and corner tests (0, 1, all-ones and min-negative combinations) for WIDTH=8 and WIDTH=64, and with MUL_MID_REG_EN undefined (L=2).
